// File: rtl/gcd_pkg.sv
// Shared encodings for the parametrised GCD engine: FSM state codes and
// algorithm mode select values.
package gcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_CAL    = 2'b01,
        ST_FINISH = 2'b10
    } state_e;

    localparam logic MODE_SUB = 1'b0;
    localparam logic MODE_BIN = 1'b1;

endpackage

// File: rtl/gcd_step_unit.sv
// One combinational GCD iteration: termination/result detection, then either
// a subtractive Euclid step or a binary (Stein) step depending on mode_r.
module gcd_step_unit
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int KW    = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] a_r,
    input  logic [WIDTH-1:0] b_r,
    input  logic [KW-1:0]    k,
    input  logic             mode_r,
    output logic [WIDTH-1:0] next_a,
    output logic [WIDTH-1:0] next_b,
    output logic [KW-1:0]    next_k,
    output logic             term,
    output logic [WIDTH-1:0] res,
    output logic             zero_err
);

    logic             a_gt_b;
    logic [WIDTH-1:0] diff;

    // Always larger minus smaller, so the subtraction cannot wrap.
    assign a_gt_b = (a_r > b_r);
    assign diff   = a_gt_b ? (a_r - b_r) : (b_r - a_r);

    always_comb begin
        next_a   = a_r;
        next_b   = b_r;
        next_k   = k;
        term     = 1'b0;
        res      = '0;
        zero_err = 1'b0;
        if (a_r == '0 || b_r == '0) begin
            term     = 1'b1;
            res      = a_r | b_r;
            zero_err = (a_r == '0) && (b_r == '0);
        end else if (a_r == b_r) begin
            term = 1'b1;
            res  = (mode_r == MODE_BIN) ? (a_r << k) : a_r;
        end else if (mode_r == MODE_SUB || (a_r[0] && b_r[0])) begin
            if (a_gt_b) begin
                next_a = diff;
            end else begin
                next_b = diff;
            end
        end else if (!a_r[0] && !b_r[0]) begin
            next_a = a_r >> 1;
            next_b = b_r >> 1;
            next_k = k + KW'(1);
        end else if (!a_r[0]) begin
            next_a = a_r >> 1;
        end else begin
            next_b = b_r >> 1;
        end
    end

endmodule

// File: rtl/param_gcd_engine.sv
// Start/done GCD coprocessor: IDLE/CAL/FINISH FSM, saturating iteration
// counter, done-hold window and registered result outputs.
module param_gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int CW        = 17,
    parameter int DONE_HOLD = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] gcd,
    output logic             err,
    output logic [CW-1:0]    cycles
);

    localparam int KW = $clog2(WIDTH) + 1;
    localparam int HW = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(DONE_HOLD - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [KW-1:0]    k_q, k_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] step_a, step_b, step_res;
    logic [KW-1:0]    step_k;
    logic             step_term, step_zero_err;

    gcd_step_unit #(
        .WIDTH (WIDTH),
        .KW    (KW)
    ) u_step (
        .a_r      (a_q),
        .b_r      (b_q),
        .k        (k_q),
        .mode_r   (mode_q),
        .next_a   (step_a),
        .next_b   (step_b),
        .next_k   (step_k),
        .term     (step_term),
        .res      (step_res),
        .zero_err (step_zero_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            mode_q  <= 1'b0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            mode_q  <= mode_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        mode_d  = mode_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            ST_CAL: begin
                // The terminating cycle is counted as a CAL cycle too.
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
                a_d   = step_a;
                b_d   = step_b;
                k_d   = step_k;
                if (step_term) begin
                    state_d = ST_FINISH;
                    res_d   = step_res;
                    err_d   = step_zero_err;
                    hold_d  = HOLD_LAST;
                end
            end
            ST_FINISH: begin
                if (hold_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            default: begin
                // IDLE, and the unused encoding which behaves as IDLE.
                state_d = ST_IDLE;
                if (start) begin
                    state_d = ST_CAL;
                    a_d     = a;
                    b_d     = b;
                    mode_d  = mode;
                    k_d     = '0;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    assign busy   = (state_q == ST_CAL);
    assign done   = (state_q == ST_FINISH);
    assign gcd    = done ? res_q : '0;
    assign err    = done & err_q;
    assign cycles = done ? cnt_q : '0;

endmodule
